// File: rtl/tqvp_bus_host_if.sv
`default_nettype none
// ============================================================================
// Module   : tqvp_bus_host_if
// Brief    : Command/response channels, TinyQV peripheral bus and interrupt
//            lines of the bus host, grouped for port connection.
// Revision : 1.0
// ============================================================================
interface tqvp_bus_host_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [1:0]  cmd_size;
    logic [5:0]  cmd_addr;
    logic [31:0] cmd_wdata;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    logic [5:0]  address;
    logic [31:0] data_in;
    logic [1:0]  data_write_n;
    logic [1:0]  data_read_n;
    logic [31:0] data_out;
    logic        data_ready;

    logic        user_interrupt;
    logic        irq_clear;
    logic        irq_pending;

    modport master (
        input  cmd_valid, cmd_write, cmd_size, cmd_addr, cmd_wdata,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        input  rsp_ready,
        output address, data_in, data_write_n, data_read_n,
        input  data_out, data_ready,
        input  user_interrupt, irq_clear,
        output irq_pending
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_size, cmd_addr, cmd_wdata,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        output rsp_ready,
        input  address, data_in, data_write_n, data_read_n,
        output data_out, data_ready,
        output user_interrupt, irq_clear,
        input  irq_pending
    );
endinterface
`default_nettype wire

// File: rtl/tqvp_bus_host.sv
`default_nettype none
// ============================================================================
// Module   : tqvp_bus_host
// Brief    : Single-outstanding bus initiator for TinyQV peripheral registers
//            with sticky interrupt capture. Define TQVP_HOST_TIMEOUT_EN to
//            abort reads after TIMEOUT_CYCLES cycles of data_ready low.
// Revision : 1.0
// ============================================================================
module tqvp_bus_host #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 8
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    tqvp_bus_host_if.master bus
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_READ  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255 ||
        TIMEOUT_CYCLES >= (1 << CNT_W)) begin : g_bad_timeout
        $error("tqvp_bus_host: TIMEOUT_CYCLES out of range for CNT_W");
    end

    logic [1:0]  state_q,    state_d;
    logic [5:0]  addr_q,     addr_d;
    logic [31:0] wdata_q,    wdata_d;
    logic [1:0]  size_q,     size_d;
    logic [31:0] rdata_q,    rdata_d;
    logic        err_q,      err_d;
    logic        irq_prev_q, irq_prev_d;
    logic        irq_pend_q, irq_pend_d;
`ifdef TQVP_HOST_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    logic        illegal;
    logic [31:0] read_masked;
    logic        cmd_ready;
    logic        rsp_valid;
    logic [1:0]  write_n;
    logic [1:0]  read_n;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            size_q     <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            irq_prev_q <= 1'b0;
            irq_pend_q <= 1'b0;
`ifdef TQVP_HOST_TIMEOUT_EN
            cnt_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            size_q     <= size_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            irq_prev_q <= irq_prev_d;
            irq_pend_q <= irq_pend_d;
`ifdef TQVP_HOST_TIMEOUT_EN
            cnt_q      <= cnt_d;
`endif
        end
    end

    // Size 11 and any access not naturally aligned to its size never reach the bus.
    always_comb begin
        illegal = (bus.cmd_size == 2'b11) ||
                  (bus.cmd_size == 2'b01 && bus.cmd_addr[0]) ||
                  (bus.cmd_size == 2'b10 && bus.cmd_addr[1:0] != 2'b00);
    end

    always_comb begin
        case (size_q)
            2'b00:   read_masked = {24'h0, bus.data_out[7:0]};
            2'b01:   read_masked = {16'h0, bus.data_out[15:0]};
            default: read_masked = bus.data_out;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        size_d     = size_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
`ifdef TQVP_HOST_TIMEOUT_EN
        cnt_d      = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    addr_d  = bus.cmd_addr;
                    wdata_d = bus.cmd_wdata;
                    size_d  = bus.cmd_size;
                    rdata_d = '0;
                    err_d   = 1'b0;
                    if (illegal) begin
                        state_d = ST_RESP;
                        err_d   = 1'b1;
                    end else if (bus.cmd_write) begin
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_READ;
`ifdef TQVP_HOST_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end
                end
            end
            ST_WRITE: begin
                state_d = ST_RESP;
                rdata_d = '0;
                err_d   = 1'b0;
            end
            ST_READ: begin
                if (bus.data_ready) begin
                    state_d = ST_RESP;
                    rdata_d = read_masked;
                    err_d   = 1'b0;
                end
`ifdef TQVP_HOST_TIMEOUT_EN
                else begin
                    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (cnt_d == CNT_W'(TIMEOUT_CYCLES)) begin
                        state_d = ST_RESP;
                        rdata_d = '0;
                        err_d   = 1'b1;
                    end
                end
`endif
            end
            default: begin
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    // Interrupt capture runs regardless of the command FSM; a new edge beats a clear.
    always_comb begin
        irq_prev_d = bus.user_interrupt;
        irq_pend_d = irq_pend_q;
        if (bus.user_interrupt && !irq_prev_q) begin
            irq_pend_d = 1'b1;
        end else if (bus.irq_clear) begin
            irq_pend_d = 1'b0;
        end
    end

    always_comb begin
        cmd_ready = (state_q == ST_IDLE);
        rsp_valid = (state_q == ST_RESP);
        write_n   = (state_q == ST_WRITE) ? size_q : 2'b11;
        read_n    = (state_q == ST_READ)  ? size_q : 2'b11;
    end

    assign bus.cmd_ready    = cmd_ready;
    assign bus.rsp_valid    = rsp_valid;
    assign bus.rsp_rdata    = rdata_q;
    assign bus.rsp_err      = err_q;
    assign bus.address      = addr_q;
    assign bus.data_in      = wdata_q;
    assign bus.data_write_n = write_n;
    assign bus.data_read_n  = read_n;
    assign bus.irq_pending  = irq_pend_q;

endmodule
`default_nettype wire

// File: tb/tb_tqvp_bus_host.sv
`default_nettype none
// ============================================================================
// Module   : tb_tqvp_bus_host
// Brief    : Self-checking bench for tqvp_bus_host against a transaction-level
//            model of command latency, strobes, response and interrupt flag.
// Revision : 1.0
// ============================================================================
module tb_tqvp_bus_host;
    localparam int TB_TIMEOUT = 4;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_mis;

    tqvp_bus_host_if bus_if ();

    tqvp_bus_host #(
        .TIMEOUT_CYCLES (TB_TIMEOUT),
        .CNT_W          (8)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One command end to end: expected latency, strobe counts and response come
    // from the protocol rules, with the peripheral holding data_ready low for
    // 'low' strobe cycles and the consumer stalling the response 'dly' cycles.
    task automatic run_txn(input logic wr, input logic [1:0] size, input logic [5:0] addr,
                           input logic [31:0] wdata, input int low, input int dly,
                           input logic [31:0] dout);
        logic        illegal;
        int          exp_lat, exp_wcnt, exp_rcnt;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          cyc, wcnt, rcnt;

        illegal = (size == 2'd3) || (size == 2'd1 && addr[0]) ||
                  (size == 2'd2 && addr[1:0] != 2'd0);
        exp_rdata = 32'h0;
        exp_err   = 1'b0;
        exp_wcnt  = 0;
        exp_rcnt  = 0;
        if (illegal) begin
            exp_lat = 1;
            exp_err = 1'b1;
        end else if (wr) begin
            exp_lat  = 2;
            exp_wcnt = 1;
        end else begin
            exp_lat   = low + 2;
            exp_rcnt  = low + 1;
            exp_rdata = (size == 2'd0) ? (dout % 32'h100) :
                        (size == 2'd1) ? (dout % 32'h10000) : dout;
`ifdef TQVP_HOST_TIMEOUT_EN
            if (low >= TB_TIMEOUT) begin
                exp_lat   = TB_TIMEOUT + 1;
                exp_rcnt  = TB_TIMEOUT;
                exp_err   = 1'b1;
                exp_rdata = 32'h0;
            end
`endif
        end

        check_eq("cmd_ready_idle", bus_if.cmd_ready, 1);
        bus_if.cmd_valid  = 1'b1;
        bus_if.cmd_write  = wr;
        bus_if.cmd_size   = size;
        bus_if.cmd_addr   = addr;
        bus_if.cmd_wdata  = wdata;
        bus_if.data_out   = dout;
        bus_if.data_ready = 1'b0;
        bus_if.rsp_ready  = 1'b0;
        step();
        bus_if.cmd_valid = 1'b0;
        bus_if.cmd_write = 1'($urandom_range(0, 1));
        bus_if.cmd_size  = 2'($urandom_range(0, 3));
        bus_if.cmd_addr  = 6'($urandom);
        bus_if.cmd_wdata = $urandom;

        cyc  = 1;
        wcnt = 0;
        rcnt = 0;
        while (!bus_if.rsp_valid && cyc < 300) begin
            check_eq("cmd_ready_busy", bus_if.cmd_ready, 0);
            if (bus_if.data_write_n != 2'b11) begin
                wcnt++;
                check_eq("wr_strobe", bus_if.data_write_n, size);
                check_eq("wr_address", bus_if.address, addr);
                check_eq("wr_data_in", bus_if.data_in, wdata);
            end
            if (bus_if.data_read_n != 2'b11) begin
                rcnt++;
                check_eq("rd_strobe", bus_if.data_read_n, size);
                check_eq("rd_address", bus_if.address, addr);
            end
            bus_if.data_ready = wr ? 1'($urandom_range(0, 1)) : (rcnt > low);
            step();
            cyc++;
        end
        check_eq("rsp_valid_seen", bus_if.rsp_valid, 1);
        check_eq("latency", cyc, exp_lat);
        check_eq("wr_strobe_cycles", wcnt, exp_wcnt);
        check_eq("rd_strobe_cycles", rcnt, exp_rcnt);
        check_eq("rsp_rdata", bus_if.rsp_rdata, exp_rdata);
        check_eq("rsp_err", bus_if.rsp_err, exp_err);
        check_eq("resp_wr_idle", bus_if.data_write_n, 2'b11);
        check_eq("resp_rd_idle", bus_if.data_read_n, 2'b11);
        bus_if.data_ready = 1'b0;

        for (int i = 0; i < dly; i++) begin
            bus_if.cmd_valid = 1'($urandom_range(0, 1));
            bus_if.cmd_size  = 2'($urandom_range(0, 2));
            step();
            check_eq("bp_rsp_valid", bus_if.rsp_valid, 1);
            check_eq("bp_rsp_rdata", bus_if.rsp_rdata, exp_rdata);
            check_eq("bp_rsp_err", bus_if.rsp_err, exp_err);
            check_eq("bp_cmd_ready", bus_if.cmd_ready, 0);
            check_eq("bp_wr_idle", bus_if.data_write_n, 2'b11);
            check_eq("bp_rd_idle", bus_if.data_read_n, 2'b11);
        end
        bus_if.cmd_valid = 1'b0;
        bus_if.rsp_ready = 1'b1;
        step();
        bus_if.rsp_ready = 1'b0;
        check_eq("done_rsp_valid", bus_if.rsp_valid, 0);
        check_eq("done_cmd_ready", bus_if.cmd_ready, 1);
        check_eq("done_address_hold", bus_if.address, addr);
    endtask

    initial begin
        logic        ui, clr, prev_ui, pend;
        logic [1:0]  sz;
        logic [5:0]  ad;

        n_cmp = 0;
        n_mis = 0;
        rst_n = 1'b0;
        bus_if.cmd_valid      = 1'b0;
        bus_if.cmd_write      = 1'b0;
        bus_if.cmd_size       = 2'b00;
        bus_if.cmd_addr       = 6'h00;
        bus_if.cmd_wdata      = 32'h0;
        bus_if.rsp_ready      = 1'b0;
        bus_if.data_out       = 32'h0;
        bus_if.data_ready     = 1'b0;
        bus_if.user_interrupt = 1'b0;
        bus_if.irq_clear      = 1'b0;
        repeat (3) step();

        check_eq("rst_cmd_ready", bus_if.cmd_ready, 1);
        check_eq("rst_rsp_valid", bus_if.rsp_valid, 0);
        check_eq("rst_rsp_rdata", bus_if.rsp_rdata, 0);
        check_eq("rst_rsp_err", bus_if.rsp_err, 0);
        check_eq("rst_address", bus_if.address, 0);
        check_eq("rst_data_in", bus_if.data_in, 0);
        check_eq("rst_write_n", bus_if.data_write_n, 2'b11);
        check_eq("rst_read_n", bus_if.data_read_n, 2'b11);
        check_eq("rst_irq_pending", bus_if.irq_pending, 0);
        rst_n = 1'b1;
        step();

        run_txn(1'b1, 2'd2, 6'h20, 32'hA5A5_1234, 0, 0, 32'h0);
        run_txn(1'b0, 2'd0, 6'h19, 32'h0, 0, 0, 32'hDEAD_BE7F);
        run_txn(1'b0, 2'd1, 6'h24, 32'h0, 3, 0, 32'h1234_5678);
        run_txn(1'b1, 2'd3, 6'h00, 32'h1111_1111, 0, 1, 32'h0);
        run_txn(1'b0, 2'd2, 6'h02, 32'h0, 0, 0, 32'hFFFF_FFFF);
        run_txn(1'b1, 2'd1, 6'h01, 32'h2222_2222, 0, 0, 32'h0);
        run_txn(1'b0, 2'd2, 6'h3C, 32'h0, 1, 5, 32'hCAFE_F00D);
`ifdef TQVP_HOST_TIMEOUT_EN
        run_txn(1'b0, 2'd2, 6'h08, 32'h0, 50, 1, 32'h5555_AAAA);
        run_txn(1'b0, 2'd0, 6'h09, 32'h0, TB_TIMEOUT - 1, 0, 32'h0000_00C3);
`endif

        for (int t = 0; t < 60; t++) begin
            sz = 2'($urandom_range(0, 3));
            ad = 6'($urandom);
            if ($urandom_range(0, 3) != 0) begin
                ad = (sz == 2'd1) ? {ad[5:1], 1'b0} : (sz == 2'd2) ? {ad[5:2], 2'b00} : ad;
            end
            run_txn(1'($urandom_range(0, 1)), sz, ad, $urandom,
                    int'($urandom_range(0, 5)), int'($urandom_range(0, 3)), $urandom);
        end

        // Reset in the middle of a read abandons it without a response.
        bus_if.cmd_valid  = 1'b1;
        bus_if.cmd_write  = 1'b0;
        bus_if.cmd_size   = 2'd0;
        bus_if.cmd_addr   = 6'h11;
        bus_if.data_ready = 1'b0;
        step();
        bus_if.cmd_valid = 1'b0;
        check_eq("midrd_strobe", bus_if.data_read_n, 2'b00);
        step();
        rst_n = 1'b0;
        step();
        check_eq("midrd_rst_read_n", bus_if.data_read_n, 2'b11);
        check_eq("midrd_rst_rsp_valid", bus_if.rsp_valid, 0);
        check_eq("midrd_rst_cmd_ready", bus_if.cmd_ready, 1);
        check_eq("midrd_rst_address", bus_if.address, 0);
        rst_n = 1'b1;
        step();
        check_eq("midrd_after_rsp_valid", bus_if.rsp_valid, 0);
        check_eq("midrd_after_read_n", bus_if.data_read_n, 2'b11);

        // Interrupt: rising edge with a simultaneous clear still sets the flag.
        prev_ui = 1'b0;
        pend    = 1'b0;
        bus_if.user_interrupt = 1'b1;
        bus_if.irq_clear      = 1'b1;
        step();
        pend    = 1'b1;
        prev_ui = 1'b1;
        check_eq("irq_set_beats_clear", bus_if.irq_pending, pend);
        step();
        pend = 1'b0;
        check_eq("irq_cleared", bus_if.irq_pending, pend);
        bus_if.irq_clear = 1'b0;
        for (int i = 0; i < 120; i++) begin
            ui  = 1'($urandom_range(0, 1));
            clr = ($urandom_range(0, 3) == 0);
            bus_if.user_interrupt = ui;
            bus_if.irq_clear      = clr;
            step();
            if (ui && !prev_ui) pend = 1'b1;
            else if (clr)       pend = 1'b0;
            prev_ui = ui;
            check_eq("irq_pending", bus_if.irq_pending, pend);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/tqvp_bus_host.md
Name: tqvp_bus_host

Overview:
- Bus initiator for the TinyQV peripheral register interface. It drives peripheral blocks the same way the TinyQV core does.
- Accepts single register-access commands over a valid/ready channel, sequences the address/strobe/data_ready handshake, and returns read data or error status over a valid/ready response channel.
- Used as a debug/test bridge and as a stand-alone host for exercising peripherals without the core.
- Also captures the peripheral's user_interrupt as a sticky pending flag.

Parameters:
- TIMEOUT_CYCLES, 16, read cycles allowed with data_ready low before abort (used only with TQVP_HOST_TIMEOUT_EN; min 1, max 255).
- CNT_W, 8, width of timeout counter.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, synchronous, active-low
- cmd_valid  input  1  command present
- cmd_ready  output  1  host can accept command
- cmd_write  input  1  1=write, 0=read
- cmd_size  input  2  00=8b, 01=16b, 10=32b, 11=illegal
- cmd_addr  input  6  peripheral register address
- cmd_wdata  input  32  write data
- rsp_valid  output  1  response present
- rsp_ready  input  1  response consumer ready
- rsp_rdata  output  32  read data, zero-extended to size; 0 for writes/errors
- rsp_err  output  1  illegal size, misalignment, or timeout
- address  output  6  to peripheral address
- data_in  output  32  to peripheral write data
- data_write_n  output  2  to peripheral; 11=idle
- data_read_n  output  2  to peripheral; 11=idle
- data_out  input  32  from peripheral read data
- data_ready  input  1  from peripheral read-complete
- user_interrupt  input  1  from peripheral interrupt
- irq_clear  input  1  clears irq_pending
- irq_pending  output  1  sticky interrupt flag

Behaviour:
- Reset (rst_n low at clk edge): state IDLE.
  - cmd_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - address=0, data_in=0, data_write_n=11, data_read_n=11.
  - irq_pending=0, timeout counter=0.
  - Reset mid-transaction aborts it immediately: strobes return to 11 and no response is issued.
- FSM states: IDLE, WRITE, READ, RESP.
- IDLE:
  - cmd_ready=1. On cmd_valid&&cmd_ready, register addr, wdata and size.
  - Illegal command (size 11; size 01 with addr[0]=1; size 10 with addr[1:0]!=0): go to RESP with rsp_err=1, rdata=0. No bus strobe.
  - Legal write: go to WRITE.
  - Legal read: go to READ.
- WRITE:
  - Lasts exactly 1 cycle. data_write_n=cmd_size; address and data_in hold the registered values.
  - data_ready is ignored.
  - Next state RESP with err=0, rdata=0.
- READ:
  - data_read_n=cmd_size, held until data_ready is sampled 1.
  - On that same cycle: capture data_out masked to size (8b: [7:0], 16b: [15:0], upper bits 0), go to RESP.
  - Strobe is 11 in the following cycle.
- RESP:
  - rsp_valid=1, with rsp_rdata/rsp_err stable until rsp_valid&&rsp_ready, then IDLE.
  - cmd_ready=0 in every state except IDLE. One outstanding command max.
- address and data_in keep their last values when idle. They do not toggle back to 0.
- Latency, accept at cycle 0:
  - Write or illegal command: rsp_valid at cycle 2 (illegal at cycle 1).
  - Read with data_ready already high: rsp_valid at cycle 2.
  - Each additional cycle of data_ready low adds 1.
- Response backpressure: if rsp_ready is held low, the FSM stays in RESP indefinitely. No new bus access occurs.
- Interrupt:
  - irq_pending sets on a rising edge of user_interrupt (registered previous value).
  - It clears on irq_clear=1.
  - If a set and a clear happen in the same cycle, set wins.
  - Independent of the FSM.

Optional Feature:
- Macro TQVP_HOST_TIMEOUT_EN.
- Defined:
  - In READ, the counter increments each cycle data_ready=0.
  - When the counter reaches TIMEOUT_CYCLES, the read is aborted: data_read_n=11 next cycle, go to RESP with err=1, rdata=0.
  - data_ready=1 on the same cycle the limit is reached counts as success.
  - Counter clears on entry to READ.
- Undefined:
  - No counter logic. READ waits for data_ready indefinitely.
  - Timeout never produces err.

Test Plan:
- Write 32b addr 0x20 data 0xA5A5_1234, rsp_ready=1 -> data_write_n=10 for exactly 1 cycle with address=0x20, data_in=0xA5A5_1234; rsp_valid cycle 2, err=0, rdata=0.
- Read 8b addr 0x19, peripheral data_ready=1, data_out=0xDEAD_BE7F -> data_read_n=00 for 1 cycle; rsp_rdata=0x0000_007F, err=0.
- Read 16b addr 0x24, data_ready low 3 cycles then high with data_out=0x1234_5678 -> strobe held 4 cycles, rsp_rdata=0x0000_5678 at cycle 5.
- Illegal commands: size 11 at addr 0; size 10 at addr 0x02; size 01 at addr 0x01 -> each gives err=1, rdata=0, and data_write_n/data_read_n stay 11 throughout.
- rsp_ready low 5 cycles after a read -> rsp_valid/rdata stable, cmd_ready=0, no strobes. user_interrupt 0->1 while irq_clear=1 -> irq_pending=1; irq_clear next cycle -> 0.
- With TQVP_HOST_TIMEOUT_EN and TIMEOUT_CYCLES=4, data_ready stuck 0 -> err=1, rdata=0, data_read_n back to 11. Reset asserted mid-READ -> strobe=11, rsp_valid=0 next cycle.
